data_mem_unit: RTL

Data-memory responder for the RV32I single-cycle datapath. It receives load/store requests and serves them from an internal word-organised synchronous RAM.
- Request address comes from the ALU result; store data comes from register-file read port 2.
- Load data is returned on o_data_mem to the writeback mux.
- The block performs RV32I byte/half/word lane steering, sign/zero extension, byte-enable generation, and misalignment/illegal-op fault detection, under a request/ready handshake.

---
 rtl/dmem_pkg.sv | 49 ++++
 rtl/dmem_lane_align.sv | 72 +++++++
 rtl/data_mem_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the RV32I data-memory responder:
//   - funct3 encodings for load/store width and signedness
//   - FSM state type used by data_mem_unit
//   - is_legal():      funct3 valid for the given direction (load/store)
//   - is_misaligned(): address low bits incompatible with the access width
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_READ = 2'd1,
        ST_LD_RESP = 2'd2,
        ST_FAULT   = 2'd3
    } dmem_state_e;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte accesses can never be misaligned; unknown funct3 values are
    // reported through is_legal instead.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for both directions.
// Store side:
//   st_funct3_i, st_addr_lo_i, st_wdata_i -> st_be_o (byte enables),
//                                            st_wword_o (lane-replicated data)
// Load side:
//   ld_funct3_i, ld_addr_lo_i, ld_word_i  -> ld_data_o (sign/zero extended)
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wword_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign ld_lane[gi] = ld_word_i[8*gi +: 8];
        end
    endgenerate

    // Replicating the narrow data across all lanes lets the RAM write
    // each lane straight from its own slice; the enables pick the target.
    always_comb begin
        st_be_o    = 4'b0000;
        st_wword_o = st_wdata_i;
        case (st_funct3_i)
            F3_B: begin
                st_be_o    = 4'b0001 << st_addr_lo_i;
                st_wword_o = {4{st_wdata_i[7:0]}};
            end
            F3_H: begin
                st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wword_o = {2{st_wdata_i[15:0]}};
            end
            F3_W: begin
                st_be_o    = 4'b1111;
                st_wword_o = st_wdata_i;
            end
            default: begin
                st_be_o    = 4'b0000;
                st_wword_o = st_wdata_i;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_lane[ld_addr_lo_i];
        ld_half = ld_addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'b0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'b0, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
// RV32I data-memory responder: word-organised synchronous RAM with byte
// enables, lane steering, sign/zero extension and fault detection behind a
// request/ready handshake.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset (control/output state only)
//   i_req       request valid, accepted when i_req & o_ready
//   i_we        1 = store, 0 = load
//   i_funct3    width/signedness selector
//   i_addr      byte address (bits above the RAM index are ignored)
//   i_wdata     right-aligned store data
//   o_ready     high when a request can be accepted
//   o_rvalid    one-cycle pulse with new load data
//   o_data_mem  extended load result, held until the next load completes
//   o_fault     one-cycle pulse for a misaligned or illegal request
// -----------------------------------------------------------------------------
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_rvalid,
    output logic [31:0] o_data_mem,
    output logic        o_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e state_q;
    logic        rvalid_q;
    logic        fault_q;
    logic [31:0] data_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic          accept;
    logic          req_ok;
    logic          st_en;
    logic          ld_en;
    logic [3:0]    st_be;
    logic [31:0]   st_wword;
    logic [31:0]   ld_data;
    logic          unused_addr_hi;

    assign widx           = i_addr[AW+1:2];
    assign unused_addr_hi = ^i_addr[31:AW+2];

    // Gating with rst keeps a request presented during reset from touching
    // the RAM, whose write port has no reset.
    assign o_ready = (state_q == ST_IDLE) & rst;
    assign accept  = i_req & o_ready;
    assign req_ok  = is_legal(i_we, i_funct3) & ~is_misaligned(i_funct3, i_addr[1:0]);
    assign st_en   = accept & req_ok & i_we;
    assign ld_en   = accept & req_ok & ~i_we;

    dmem_lane_align u_lane_align (
        .st_funct3_i  (i_funct3),
        .st_addr_lo_i (i_addr[1:0]),
        .st_wdata_i   (i_wdata),
        .st_be_o      (st_be),
        .st_wword_o   (st_wword),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_lo_q),
        .ld_word_i    (rdata_q),
        .ld_data_o    (ld_data)
    );

    // RAM: byte-enabled write and registered read, no reset so it maps onto
    // block RAM and keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem[widx][8*b +: 8] <= st_wword[8*b +: 8];
                end
            end
        end
        if (ld_en) begin
            rdata_q <= mem[widx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rvalid_q  <= 1'b0;
            fault_q   <= 1'b0;
            data_q    <= '0;
            addr_lo_q <= '0;
            funct3_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!req_ok) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else if (!i_we) begin
                            state_q   <= ST_LD_READ;
                            addr_lo_q <= i_addr[1:0];
                            funct3_q  <= i_funct3;
                        end
                    end
                end
                ST_LD_READ: begin
                    data_q   <= ld_data;
                    rvalid_q <= 1'b1;
                    state_q  <= ST_LD_RESP;
                end
                ST_LD_RESP: begin
                    rvalid_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                ST_FAULT: begin
                    fault_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rvalid   = rvalid_q;
    assign o_fault    = fault_q;
    assign o_data_mem = data_q;

endmodule
